// File: rtl/psum_ofifo.sv
// psum_ofifo: output FIFO bank between the MAC array's bottom row and the SFU
// column array. Each column has its own FIFO because the bottom row produces
// its partial sums at skewed times. A full row is released only once every
// column holds data, and the popped row is registered so it can drive sfu_in
// directly.
//
// Build option: define PSUM_OFIFO_STATUS_EN to add the sticky ovf/udf status
// outputs. The datapath is identical with or without it.
//
// Handshake: a row pop is accepted on a rising edge when rd=1 and o_valid=1.
// o_valid, o_full and o_ready depend only on registered pointers. A write to
// column i is accepted when wr[i]=1 and the column is not full, or when a pop
// is accepted in the same cycle. An accepted pop at edge N loads out and
// raises out_vld for the single cycle that follows edge N.
module psum_ofifo #(
    parameter int col        = 8,
    parameter int psum_bw    = 16,
    parameter int fifo_depth = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr,
    input  logic [col*psum_bw-1:0] in,
    input  logic                   rd,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic [col*psum_bw-1:0] out,
    output logic                   out_vld
`ifdef PSUM_OFIFO_STATUS_EN
    ,
    output logic                   ovf,
    output logic                   udf
`endif
);

    // Address bits index the storage. The pointer carries one extra wrap bit
    // so that a full FIFO and an empty FIFO can be told apart.
    localparam int aw = $clog2(fifo_depth);
    localparam int pw = aw + 1;

    // Per-column storage. It is not reset: the pointers alone decide which
    // entries are live.
    logic [psum_bw-1:0] mem [col][fifo_depth];

    logic [pw-1:0] wr_ptr [col];
    logic [pw-1:0] rd_ptr [col];

    // Unpacked views of the flat column buses.
    logic [col-1:0][psum_bw-1:0] in_cols;
    logic [col-1:0][psum_bw-1:0] out_q;

    logic [col-1:0] col_empty;
    logic [col-1:0] col_full;
    logic [col-1:0] wr_ok;
    logic           pop;

    assign in_cols = in;
    assign out     = out_q;

    // Per-column empty/full flags, decoded from the registered pointers only.
    always_comb begin
        col_empty = '0;
        col_full  = '0;
        for (int i = 0; i < col; i++) begin
            col_empty[i] = (wr_ptr[i] == rd_ptr[i]);
            col_full[i]  = (wr_ptr[i][aw] != rd_ptr[i][aw]) &&
                           (wr_ptr[i][aw-1:0] == rd_ptr[i][aw-1:0]);
        end
    end

    // A row is ready only when every column holds at least one word. A word
    // written this cycle is not counted until the pointer has moved.
    assign o_valid = ~|col_empty;
    assign o_full  = |col_full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    // A pop in the same cycle frees the head slot, so a full column may still
    // accept a write. The pop reads the old head before the write lands.
    always_comb begin
        wr_ok = '0;
        for (int i = 0; i < col; i++) begin
            wr_ok[i] = wr[i] & (~col_full[i] | pop);
        end
    end

    // Store accepted writes. The strobes in a reset cycle are ignored.
    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (!reset && wr_ok[i]) begin
                mem[i][wr_ptr[i][aw-1:0]] <= in_cols[i];
            end
        end
    end

    // Advance the write pointers on accepted writes and the read pointers on
    // accepted pops. The pointers wrap naturally modulo 2*fifo_depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < col; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < col; i++) begin
                if (wr_ok[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
            end
        end
    end

    // Register the popped row. out holds its value until the next pop, and
    // out_vld marks the cycle in which it changed.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= pop;
            if (pop) begin
                for (int i = 0; i < col; i++) begin
                    out_q[i] <= mem[i][rd_ptr[i][aw-1:0]];
                end
            end
        end
    end

`ifdef PSUM_OFIFO_STATUS_EN
    // Sticky status. ovf records any write dropped on a full column. udf
    // records any pop request made while no complete row was available.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (|(wr & ~wr_ok)) begin
                ovf <= 1'b1;
            end
            if (rd && !o_valid) begin
                udf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_psum_ofifo.sv
// Self-checking bench for psum_ofifo. The reference model is one queue per
// column plus an expected-row queue that is filled when a pop is requested
// and drained when out_vld appears.
module tb_psum_ofifo;

    localparam int n_col = 8;
    localparam int bw    = 16;
    localparam int depth = 64;
    localparam int dw    = n_col * bw;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [n_col-1:0] wr;
    logic [dw-1:0]    in;
    logic             rd;
    logic             o_valid;
    logic             o_full;
    logic             o_ready;
    logic [dw-1:0]    out;
    logic             out_vld;
`ifdef PSUM_OFIFO_STATUS_EN
    logic             ovf;
    logic             udf;
`endif

    psum_ofifo #(
        .col        (n_col),
        .psum_bw    (bw),
        .fifo_depth (depth)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .in      (in),
        .rd      (rd),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready),
        .out     (out),
        .out_vld (out_vld)
`ifdef PSUM_OFIFO_STATUS_EN
        ,
        .ovf     (ovf),
        .udf     (udf)
`endif
    );

    // ---------------- scoreboard / model ----------------
    logic [bw-1:0] model_q [n_col][$];
    logic [dw-1:0] exp_q [$];
    logic [dw-1:0] last_out;
    logic          ovf_m;
    logic          udf_m;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [dw-1:0] act, input logic [dw-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic model_valid();
        logic v = 1'b1;
        for (int i = 0; i < n_col; i++) begin
            if (model_q[i].size() == 0) v = 1'b0;
        end
        return v;
    endfunction

    function automatic logic model_full();
        logic f = 1'b0;
        for (int i = 0; i < n_col; i++) begin
            if (model_q[i].size() == depth) f = 1'b1;
        end
        return f;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < n_col; i++) model_q[i].delete();
        exp_q.delete();
        last_out = '0;
        ovf_m    = 1'b0;
        udf_m    = 1'b0;
    endfunction

    // Build a row where column i carries base + i*stride.
    function automatic logic [dw-1:0] make_row(input int base, input int stride);
        logic [dw-1:0] r = '0;
        for (int i = 0; i < n_col; i++) begin
            r[i*bw +: bw] = bw'(base + i * stride);
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // One clock cycle: drive inputs, check flags against the model, update the
    // model, then check the registered output after the edge.
    task automatic step(input logic [n_col-1:0] w, input logic [dw-1:0] d, input logic r);
        logic          pop_m;
        logic [dw-1:0] row;
        @(negedge clk);
        wr = w;
        in = d;
        rd = r;
        #1;
        check("o_valid", {{(dw-1){1'b0}}, o_valid}, {{(dw-1){1'b0}}, model_valid()});
        check("o_full",  {{(dw-1){1'b0}}, o_full},  {{(dw-1){1'b0}}, model_full()});
        check("o_ready", {{(dw-1){1'b0}}, o_ready}, {{(dw-1){1'b0}}, ~model_full()});
        pop_m = r && model_valid();
        if (r && !model_valid()) udf_m = 1'b1;
        if (pop_m) begin
            row = '0;
            for (int i = 0; i < n_col; i++) row[i*bw +: bw] = model_q[i].pop_front();
            exp_q.push_back(row);
        end
        for (int i = 0; i < n_col; i++) begin
            if (w[i]) begin
                if (model_q[i].size() < depth) model_q[i].push_back(d[i*bw +: bw]);
                else ovf_m = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("out_vld", {{(dw-1){1'b0}}, out_vld}, {{(dw-1){1'b0}}, pop_m});
        if (out_vld) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", out, last_out);
            end else begin
                row = exp_q.pop_front();
                check("out_row", out, row);
                last_out = row;
            end
        end else begin
            check("out_hold", out, last_out);
        end
`ifdef PSUM_OFIFO_STATUS_EN
        check("ovf", {{(dw-1){1'b0}}, ovf}, {{(dw-1){1'b0}}, ovf_m});
        check("udf", {{(dw-1){1'b0}}, udf}, {{(dw-1){1'b0}}, udf_m});
`endif
        wr = '0;
        rd = 1'b0;
    endtask

    task automatic do_reset(input logic [n_col-1:0] w);
        @(negedge clk);
        reset = 1'b1;
        wr    = w;
        in    = make_row(16'h5A00, 1);
        rd    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr    = '0;
        rd    = 1'b0;
        model_clear();
        check("rst_o_valid", {{(dw-1){1'b0}}, o_valid}, '0);
        check("rst_o_full",  {{(dw-1){1'b0}}, o_full},  '0);
        check("rst_o_ready", {{(dw-1){1'b0}}, o_ready}, {{(dw-1){1'b0}}, 1'b1});
        check("rst_out",     out, '0);
        check("rst_out_vld", {{(dw-1){1'b0}}, out_vld}, '0);
`ifdef PSUM_OFIFO_STATUS_EN
        check("rst_ovf", {{(dw-1){1'b0}}, ovf}, '0);
        check("rst_udf", {{(dw-1){1'b0}}, udf}, '0);
`endif
    endtask

    task automatic drain();
        while (model_valid()) step('0, '0, 1'b1);
        step('0, '0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [dw-1:0] d;
        int            cnt;
        reset = 1'b1;
        wr    = '0;
        in    = '0;
        rd    = 1'b0;
        repeat (2) @(posedge clk);
        do_reset('0);

        // Basic row transfer.
        step(8'hFF, make_row(16'h0100, 1), 1'b0);
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);
        check("basic_row", last_out, make_row(16'h0100, 1));

        // Skewed fill with rd held high from the first cycle.
        do_reset('0);
        for (int i = 0; i < n_col; i++) begin
            d = '0;
            d[i*bw +: bw] = bw'(16'hA000 + i);
            step(n_col'(1) << i, d, 1'b1);
        end
        for (int k = 0; k < 4; k++) step('0, '0, 1'b1);
        check("skew_row", last_out, make_row(16'hA000, 1));

        // Full / overflow on column 3, then fill the rest and drain.
        do_reset('0);
        for (int k = 0; k < depth; k++) begin
            d = '0;
            d[3*bw +: bw] = bw'(k);
            step(8'h08, d, 1'b0);
        end
        d = '0;
        d[3*bw +: bw] = 16'hFFFF;
        step(8'h08, d, 1'b0);
        for (int k = 0; k < depth; k++) begin
            d = '0;
            for (int i = 0; i < n_col; i++) d[i*bw +: bw] = bw'($urandom_range(0, 65535));
            step(8'hF7, d, 1'b0);
        end
        drain();

        // Simultaneous push and pop while every column is full.
        do_reset('0);
        for (int k = 0; k < depth; k++) step(8'hFF, make_row(k * 16, 1), 1'b0);
        step(8'hFF, make_row(16'hBEE0, 1), 1'b1);
        drain();
        check("full_pushpop_last", last_out, make_row(16'hBEE0, 1));

        // Wrap-around: continuous push/pop across several pointer wraps.
        do_reset('0);
        cnt = 0;
        step(8'hFF, make_row(cnt, 0), 1'b0);
        for (int k = 0; k < 200; k++) begin
            cnt = (cnt + 1) % 65536;
            step(8'hFF, make_row(cnt, 0), 1'b1);
        end
        drain();

        // Underflow, then reset with rows queued and writes asserted.
        do_reset('0);
        step('0, '0, 1'b1);
        for (int k = 0; k < 5; k++) step(8'hFF, make_row(16'h7000 + k * 8, 1), 1'b0);
        do_reset(8'hFF);
        step('0, '0, 1'b1);
        step(8'hFF, make_row(16'h3300, 1), 1'b0);
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);
        check("post_reset_row", last_out, make_row(16'h3300, 1));

        check("exp_q_empty", dw'(exp_q.size()), '0);

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
